instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Pipeline stage 1 of the 5-stage 64-bit ARM CPU. Holds the PC, drives a variable-latency instruction memory with a request/ready handshake, and owns the IF/ID pipeline register that feeds instruction decode. It accepts branch redirects resolved in ID and honours the hazard unit's stall. A squashed or missing fetch becomes a NOP bubble marked invalid.

## Interface

**Parameters**
- RESET_PC, default 64'h0: PC value loaded on reset.
- NOP, default 32'hD503201F: encoding placed in IDInstr for bubbles.

**Ports**
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-low reset; asserted when 0.
- IDBranchPC, in, 64: redirect target from ID.
- IDTakeBranch, in, 1: redirect request from ID; ignored while Stall=1.
- Stall, in, 1: hazard unit; holds PC and IF/ID.
- ImemReq, out, 1: fetch request; 1 only in state FETCH with reset=1.
- ImemAddr, out, 64: equals the PC register; combinational.
- ImemReady, in, 1: ImemData is valid for the current ImemAddr this cycle.
- ImemData, in, 32: instruction word.
- IFPC, out, 64: current PC; equals ImemAddr.
- IDPC, out, 64: IF/ID register, PC of IDInstr.
- IDInstr, out, 32: IF/ID register, instruction word.
- IDValid, out, 1: IF/ID register; 0 indicates a bubble.

## Operation

- State register has two states: FETCH and HOLD. Internal registers: PC, holdInstr (32 bits), and the IF/ID register.
- The memory samples ImemAddr combinationally each cycle. Changing the address abandons the access in flight. No pending-redirect state exists.
- Evaluation order each cycle in FETCH, first match wins:
  1. reset=0: PC<=RESET_PC, IDPC<=0, IDInstr<=NOP, IDValid<=0, state<=FETCH.
  2. Stall=1 and ImemReady=1: holdInstr<=ImemData, state<=HOLD. PC and IF/ID unchanged.
  3. Stall=1 and ImemReady=0: all registers unchanged.
  4. IDTakeBranch=1: PC<=IDBranchPC, IF/ID<=bubble. The word returned this cycle, if any, is discarded.
  5. ImemReady=1: IF/ID<={PC, ImemData, 1}, PC<=PC+4.
  6. ImemReady=0: IF/ID<=bubble, PC unchanged.
- Evaluation order each cycle in HOLD (ImemReq=0):
  - Stall=1: all registers unchanged.
  - Stall=0, IDTakeBranch=1: discard holdInstr, PC<=IDBranchPC, IF/ID<=bubble, state<=FETCH.
  - Stall=0, IDTakeBranch=0: IF/ID<={PC, holdInstr, 1}, PC<=PC+4, state<=FETCH.
- Bubble definition: IDPC<=PC, IDInstr<=NOP, IDValid<=0.
- PC+4 is 64-bit modulo: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0. IDBranchPC is loaded unmodified; low bits are not masked.

## Timing

- Reset values: IDPC=0, IDInstr=NOP, IDValid=0, PC/IFPC/ImemAddr=RESET_PC, ImemReq=0 while reset=0.
- First request occurs in the cycle after reset deasserts.
- Latency: word accepted at edge N (ImemReady=1) appears on IDInstr after edge N.
- Throughput: ImemReady tied to 1 gives one instruction per cycle.
- A redirect costs exactly one bubble. The target is requested the cycle after IDTakeBranch.
- Stall during a wait does not drop a word once it is returned. The word is buffered in HOLD and released on the first cycle with Stall=0.
- Reset mid-HOLD or mid-wait discards holdInstr and any in-flight fetch.

## Test plan

- Reset with RESET_PC=0x100 and ImemReady=1, data=addr-derived: IDPC sequence 0x100, 0x104, 0x108 with IDValid=1 from the second cycle after release.
- ImemReady low for 3 cycles at 0x104: three bubbles (IDValid=0, IDInstr=NOP), ImemAddr held at 0x104, then 0x104 delivered.
- IDTakeBranch=1, IDBranchPC=0x400 while fetching 0x108: one bubble, next valid IDPC=0x400, word for 0x108 never appears.
- Stall=1 for 2 cycles with ImemReady=1: IF/ID frozen, state HOLD, ImemReq=0; after release the buffered word appears once, then PC+4 resumes.
- Stall=1 with IDTakeBranch=1 concurrently: branch ignored; PC unchanged.
- PC=64'hFFFF_FFFF_FFFF_FFFC fetched: next ImemAddr=0. Reset asserted in HOLD: outputs return to reset values next edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// handshake and loads the IF/ID pipeline register feeding decode.
// A word that arrives while the stage is stalled is parked in holdInstr
// (state HOLD) and released on the first unstalled cycle.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP      = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] IDBranchPC,
  input  logic        IDTakeBranch,
  input  logic        Stall,
  output logic        ImemReq,
  output logic [63:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic [63:0] IFPC,
  output logic [63:0] IDPC,
  output logic [31:0] IDInstr,
  output logic        IDValid
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_next;
  logic [63:0] pc, pc_next;
  logic [31:0] hold_instr, hold_next;
  logic [63:0] id_pc_next;
  logic [31:0] id_instr_next;
  logic        id_valid_next;
  logic [63:0] pc_plus4;

  assign pc_plus4 = pc + 64'd4;
  assign ImemAddr = pc;
  assign IFPC     = pc;
  assign ImemReq  = (state == FETCH) && reset;

  // Register update; reset is synchronous and discards any parked word
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_instr <= NOP;
      IDPC       <= 64'd0;
      IDInstr    <= NOP;
      IDValid    <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      hold_instr <= hold_next;
      IDPC       <= id_pc_next;
      IDInstr    <= id_instr_next;
      IDValid    <= id_valid_next;
    end
  end

  // Next-state logic: stall beats redirect, redirect beats a returned word
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    hold_next     = hold_instr;
    id_pc_next    = IDPC;
    id_instr_next = IDInstr;
    id_valid_next = IDValid;
    case (state)
      FETCH: begin
        if (Stall) begin
          if (ImemReady) begin
            hold_next  = ImemData;
            state_next = HOLD;
          end
        end else if (IDTakeBranch) begin
          pc_next       = IDBranchPC;
          id_pc_next    = pc;
          id_instr_next = NOP;
          id_valid_next = 1'b0;
        end else if (ImemReady) begin
          id_pc_next    = pc;
          id_instr_next = ImemData;
          id_valid_next = 1'b1;
          pc_next       = pc_plus4;
        end else begin
          id_pc_next    = pc;
          id_instr_next = NOP;
          id_valid_next = 1'b0;
        end
      end
      HOLD: begin
        if (!Stall) begin
          state_next = FETCH;
          if (IDTakeBranch) begin
            pc_next       = IDBranchPC;
            id_pc_next    = pc;
            id_instr_next = NOP;
            id_valid_next = 1'b0;
          end else begin
            id_pc_next    = pc;
            id_instr_next = hold_instr;
            id_valid_next = 1'b1;
            pc_next       = pc_plus4;
          end
        end
      end
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected IF/ID
// words, a monitor pops them whenever a valid word is loaded into IF/ID.
module tb_instruction_fetch;

  localparam logic [63:0] RPC = 64'h100;
  localparam logic [31:0] NOP = 32'hD503201F;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [63:0] IDBranchPC;
  logic        IDTakeBranch;
  logic        Stall;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemData;
  logic [63:0] IFPC;
  logic [63:0] IDPC;
  logic [31:0] IDInstr;
  logic        IDValid;
  logic        corrupt;

  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t expQ[$];

  instruction_fetch #(.RESET_PC(RPC), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .IDBranchPC(IDBranchPC),
    .IDTakeBranch(IDTakeBranch), .Stall(Stall), .ImemReq(ImemReq),
    .ImemAddr(ImemAddr), .ImemReady(ImemReady), .ImemData(ImemData),
    .IFPC(IFPC), .IDPC(IDPC), .IDInstr(IDInstr), .IDValid(IDValid)
  );

  function automatic logic [31:0] wordOf(input logic [63:0] a);
    return {8'hAB, a[23:0]};
  endfunction

  // Memory model: address-derived word, optionally corrupted to expose
  // a design that reads live data instead of the parked word
  always_comb ImemData = wordOf(ImemAddr) ^ (corrupt ? 32'hFFFF_FFFF : 32'h0);

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic tk,
                               input logic rdy, input logic [63:0] bpc);
    reset = rst; Stall = st; IDTakeBranch = tk; ImemReady = rdy; IDBranchPC = bpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pushExp(input logic [63:0] a);
    expQ.push_back('{pc: a, instr: wordOf(a)});
  endtask

  // Monitor: IF/ID loads on every edge with reset high and Stall low;
  // each valid word loaded must match the head of the scoreboard
  always begin
    logic loaded;
    exp_t e;
    @(posedge clk);
    loaded = reset && !Stall;
    @(negedge clk);
    if (loaded && IDValid === 1'b1) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_word: got pc %h instr %h expected none", IDPC, IDInstr);
      end else begin
        e = expQ.pop_front();
        checkOutput("mon_pc", IDPC, e.pc);
        checkOutput("mon_instr", {32'd0, IDInstr}, {32'd0, e.instr});
      end
    end
  end

  // Directed sequence
  initial begin
    corrupt = 1'b0;
    applyStimulus(0, 0, 0, 1, 64'd0);
    tick(); tick();
    checkOutput("rst_idpc", IDPC, 64'd0);
    checkOutput("rst_instr", {32'd0, IDInstr}, {32'd0, NOP});
    checkOutput("rst_valid", {63'd0, IDValid}, 64'd0);
    checkOutput("rst_addr", ImemAddr, RPC);
    checkOutput("rst_ifpc", IFPC, RPC);
    checkOutput("rst_req", {63'd0, ImemReq}, 64'd0);

    applyStimulus(1, 0, 0, 1, 64'd0);
    checkOutput("first_req", {63'd0, ImemReq}, 64'd1);
    pushExp(64'h100);
    tick();
    checkOutput("addr_104", ImemAddr, 64'h104);

    applyStimulus(1, 0, 0, 0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("wait_valid", {63'd0, IDValid}, 64'd0);
      checkOutput("wait_instr", {32'd0, IDInstr}, {32'd0, NOP});
      checkOutput("wait_idpc", IDPC, 64'h104);
      checkOutput("wait_addr", ImemAddr, 64'h104);
    end

    applyStimulus(1, 0, 0, 1, 64'd0);
    pushExp(64'h104);
    tick();

    applyStimulus(1, 0, 1, 1, 64'h400);
    tick();
    checkOutput("br_valid", {63'd0, IDValid}, 64'd0);
    checkOutput("br_idpc", IDPC, 64'h108);
    checkOutput("br_addr", ImemAddr, 64'h400);
    applyStimulus(1, 0, 0, 1, 64'd0);
    pushExp(64'h400);
    tick();
    checkOutput("addr_404", ImemAddr, 64'h404);

    applyStimulus(1, 1, 0, 1, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("stall_req", {63'd0, ImemReq}, 64'd0);
      checkOutput("stall_idpc", IDPC, 64'h400);
      checkOutput("stall_valid", {63'd0, IDValid}, 64'd1);
      checkOutput("stall_addr", ImemAddr, 64'h404);
    end
    applyStimulus(1, 0, 0, 1, 64'd0);
    corrupt = 1'b1;
    pushExp(64'h404);
    tick();
    corrupt = 1'b0;
    checkOutput("release_addr", ImemAddr, 64'h408);
    checkOutput("release_req", {63'd0, ImemReq}, 64'd1);
    pushExp(64'h408);
    tick();

    applyStimulus(1, 1, 1, 0, 64'h800);
    tick();
    checkOutput("stallbr_addr", ImemAddr, 64'h40C);
    checkOutput("stallbr_idpc", IDPC, 64'h408);
    checkOutput("stallbr_req", {63'd0, ImemReq}, 64'd1);
    applyStimulus(1, 0, 0, 1, 64'd0);
    pushExp(64'h40C);
    tick();

    applyStimulus(1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    checkOutput("wrapbr_idpc", IDPC, 64'h410);
    checkOutput("wrapbr_addr", ImemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1, 0, 0, 1, 64'd0);
    pushExp(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    checkOutput("wrap_addr", ImemAddr, 64'd0);
    pushExp(64'd0);
    tick();

    applyStimulus(1, 1, 0, 1, 64'd0);
    tick();
    checkOutput("hold_req", {63'd0, ImemReq}, 64'd0);
    applyStimulus(0, 1, 0, 1, 64'd0);
    tick();
    checkOutput("rst2_idpc", IDPC, 64'd0);
    checkOutput("rst2_instr", {32'd0, IDInstr}, {32'd0, NOP});
    checkOutput("rst2_valid", {63'd0, IDValid}, 64'd0);
    checkOutput("rst2_addr", ImemAddr, RPC);
    checkOutput("rst2_req", {63'd0, ImemReq}, 64'd0);
    applyStimulus(1, 0, 0, 1, 64'd0);
    checkOutput("rst2_req_release", {63'd0, ImemReq}, 64'd1);
    pushExp(64'h100);
    tick();
    checkOutput("rst2_next_addr", ImemAddr, 64'h104);

    applyStimulus(1, 0, 0, 0, 64'd0);
    tick(); tick();
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
